// File: rtl/wb_stage_if.sv
// Writeback stage bus: execute request, data-memory response, regfile write port,
// hazard scoreboard and error pulses.
interface wb_stage_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic [31:0] ex_wd;
    logic        ex_is_load;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_addr_lo;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;
    logic        hz_pending;
    logic [4:0]  hz_rd;
    logic        err_misalign;
    logic        err_timeout;

    modport slave (
        input  ex_valid, ex_rd, ex_wd, ex_is_load, ex_funct3, ex_addr_lo,
        input  mem_rsp_valid, mem_rsp_data,
        output ex_ready, rf_we, rf_rd, rf_wd, hz_pending, hz_rd,
        output err_misalign, err_timeout
    );

    modport master (
        output ex_valid, ex_rd, ex_wd, ex_is_load, ex_funct3, ex_addr_lo,
        output mem_rsp_valid, mem_rsp_data,
        input  ex_ready, rf_we, rf_rd, rf_wd, hz_pending, hz_rd,
        input  err_misalign, err_timeout
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: ALU results write one cycle after acceptance; loads wait for the
// memory response, get extracted/extended, then write. rf_we is active-low.
module wb_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    wb_stage_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {ST_IDLE, ST_WAIT_RSP} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [4:0]       r_ld_rd, w_ld_rd_nxt;
    logic [2:0]       r_ld_f3, w_ld_f3_nxt;
    logic [1:0]       r_ld_lo, w_ld_lo_nxt;
    logic             r_rf_we, w_rf_we_nxt;
    logic [4:0]       r_rf_rd, w_rf_rd_nxt;
    logic [31:0]      r_rf_wd, w_rf_wd_nxt;
    logic             r_hz_pending, w_hz_pending_nxt;
    logic [4:0]       r_hz_rd, w_hz_rd_nxt;
    logic             r_err_misalign, w_err_misalign_nxt;
    logic             r_err_timeout, w_err_timeout_nxt;
    logic             w_ld_legal;

    // Byte/half extraction from the aligned word, then sign or zero extension.
    function automatic logic [31:0] load_fmt(input logic [31:0] data,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  lo);
        logic [7:0]  b;
        logic [15:0] h;
        b = data[{lo, 3'b000} +: 8];
        h = data[{lo[1], 4'b0000} +: 16];
        case (f3)
            F3_LB:   load_fmt = {{24{b[7]}}, b};
            F3_LH:   load_fmt = {{16{h[15]}}, h};
            F3_LBU:  load_fmt = {24'h0, b};
            F3_LHU:  load_fmt = {16'h0, h};
            default: load_fmt = data;
        endcase
    endfunction

    always_comb begin
        case (bus.ex_funct3)
            F3_LB, F3_LBU: w_ld_legal = 1'b1;
            F3_LH, F3_LHU: w_ld_legal = ~bus.ex_addr_lo[0];
            F3_LW:         w_ld_legal = (bus.ex_addr_lo == 2'b00);
            default:       w_ld_legal = 1'b0;
        endcase
    end

    assign w_cnt_inc    = r_cnt + CNT_W'(1);
    assign bus.ex_ready = (r_state == ST_IDLE);

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_ld_rd_nxt        = r_ld_rd;
        w_ld_f3_nxt        = r_ld_f3;
        w_ld_lo_nxt        = r_ld_lo;
        w_rf_we_nxt        = 1'b1;
        w_rf_rd_nxt        = r_rf_rd;
        w_rf_wd_nxt        = r_rf_wd;
        w_hz_pending_nxt   = r_hz_pending;
        w_hz_rd_nxt        = r_hz_rd;
        w_err_misalign_nxt = 1'b0;
        w_err_timeout_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.ex_valid) begin
                    if (!bus.ex_is_load) begin
                        if (bus.ex_rd != 5'd0) begin
                            w_rf_we_nxt = 1'b0;
                            w_rf_rd_nxt = bus.ex_rd;
                            w_rf_wd_nxt = bus.ex_wd;
                        end
                    end else if (!w_ld_legal) begin
                        w_err_misalign_nxt = 1'b1;
                    end else begin
                        w_ld_rd_nxt      = bus.ex_rd;
                        w_ld_f3_nxt      = bus.ex_funct3;
                        w_ld_lo_nxt      = bus.ex_addr_lo;
                        w_cnt_nxt        = '0;
                        w_state_nxt      = ST_WAIT_RSP;
                        w_hz_pending_nxt = 1'b1;
                        w_hz_rd_nxt      = bus.ex_rd;
                    end
                end
            end
            ST_WAIT_RSP: begin
                // A response arriving on the final allowed cycle still beats the timeout.
                if (bus.mem_rsp_valid) begin
                    if (r_ld_rd != 5'd0) begin
                        w_rf_we_nxt = 1'b0;
                        w_rf_rd_nxt = r_ld_rd;
                        w_rf_wd_nxt = load_fmt(bus.mem_rsp_data, r_ld_f3, r_ld_lo);
                    end
                    w_state_nxt      = ST_IDLE;
                    w_hz_pending_nxt = 1'b0;
                    w_hz_rd_nxt      = 5'd0;
                end else if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
                    w_err_timeout_nxt = 1'b1;
                    w_cnt_nxt         = '0;
                    w_state_nxt       = ST_IDLE;
                    w_hz_pending_nxt  = 1'b0;
                    w_hz_rd_nxt       = 5'd0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_ld_rd        <= 5'd0;
            r_ld_f3        <= 3'd0;
            r_ld_lo        <= 2'd0;
            r_rf_we        <= 1'b1;
            r_rf_rd        <= 5'd0;
            r_rf_wd        <= 32'd0;
            r_hz_pending   <= 1'b0;
            r_hz_rd        <= 5'd0;
            r_err_misalign <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_ld_rd        <= w_ld_rd_nxt;
            r_ld_f3        <= w_ld_f3_nxt;
            r_ld_lo        <= w_ld_lo_nxt;
            r_rf_we        <= w_rf_we_nxt;
            r_rf_rd        <= w_rf_rd_nxt;
            r_rf_wd        <= w_rf_wd_nxt;
            r_hz_pending   <= w_hz_pending_nxt;
            r_hz_rd        <= w_hz_rd_nxt;
            r_err_misalign <= w_err_misalign_nxt;
            r_err_timeout  <= w_err_timeout_nxt;
        end
    end

    assign bus.rf_we        = r_rf_we;
    assign bus.rf_rd        = r_rf_rd;
    assign bus.rf_wd        = r_rf_wd;
    assign bus.hz_pending   = r_hz_pending;
    assign bus.hz_rd        = r_hz_rd;
    assign bus.err_misalign = r_err_misalign;
    assign bus.err_timeout  = r_err_timeout;
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected writes/errors are queued at request time
// and matched against what the regfile port and error pulses show.
module tb_wb_stage;
    localparam int unsigned TIMEOUT = 16;

    localparam logic [1:0] K_WR  = 2'd0;
    localparam logic [1:0] K_MIS = 2'd1;
    localparam logic [1:0] K_TMO = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] wd;
    } ev_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    ev_t  sb_q[$];
    ev_t  exp_ev;
    logic [1:0] obs_kind;

    wb_stage_if bus ();

    wb_stage #(.TIMEOUT(TIMEOUT)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h exp 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_fmt(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = lo[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return d;
        endcase
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic push_ev(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] wd);
        ev_t e;
        e.kind = kind;
        e.rd   = rd;
        e.wd   = wd;
        sb_q.push_back(e);
    endtask

    task automatic drive_req(input logic [4:0] rd, input logic [31:0] wd, input logic is_load,
                             input logic [2:0] f3, input logic [1:0] lo);
        check_eq("ex_ready_before_req", 32'(bus.ex_ready), 32'd1);
        bus.ex_valid   = 1'b1;
        bus.ex_rd      = rd;
        bus.ex_wd      = wd;
        bus.ex_is_load = is_load;
        bus.ex_funct3  = f3;
        bus.ex_addr_lo = lo;
    endtask

    task automatic idle_req();
        bus.ex_valid   = 1'b0;
        bus.ex_is_load = 1'b0;
    endtask

    task automatic pulse_rsp(input logic [31:0] data);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = data;
        cyc();
        bus.mem_rsp_valid = 1'b0;
    endtask

    // Every observed write or error pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && (!bus.rf_we || bus.err_misalign || bus.err_timeout)) begin
            obs_kind = !bus.rf_we ? K_WR : (bus.err_misalign ? K_MIS : K_TMO);
            check_eq("sb_event_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp_ev = sb_q.pop_front();
                check_eq("sb_kind", 32'(obs_kind), 32'(exp_ev.kind));
                if (exp_ev.kind == K_WR) begin
                    check_eq("sb_rf_rd", 32'(bus.rf_rd), 32'(exp_ev.rd));
                    check_eq("sb_rf_wd", bus.rf_wd, exp_ev.wd);
                end
            end
        end
    end

    initial begin
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [31:0] data;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [2:0]  f3_tab [5];
        int          lat;

        f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
        f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.ex_valid = 1'b0; bus.ex_rd = 5'd0; bus.ex_wd = 32'd0; bus.ex_is_load = 1'b0;
        bus.ex_funct3 = 3'd0; bus.ex_addr_lo = 2'd0;
        bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = 32'd0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();

        check_eq("rst_rf_we", 32'(bus.rf_we), 32'd1);
        check_eq("rst_rf_rd", 32'(bus.rf_rd), 32'd0);
        check_eq("rst_rf_wd", bus.rf_wd, 32'd0);
        check_eq("rst_hz_pending", 32'(bus.hz_pending), 32'd0);
        check_eq("rst_hz_rd", 32'(bus.hz_rd), 32'd0);
        check_eq("rst_err", 32'({bus.err_misalign, bus.err_timeout}), 32'd0);
        check_eq("rst_ex_ready", 32'(bus.ex_ready), 32'd1);

        // ALU burst, one accept per cycle, write appears one cycle later
        for (int i = 1; i <= 3; i++) begin
            drive_req(5'(i), 32'(i * 32'h11), 1'b0, 3'd0, 2'd0);
            push_ev(K_WR, 5'(i), 32'(i * 32'h11));
            cyc();
            check_eq("burst_we_low", 32'(bus.rf_we), 32'd0);
            check_eq("burst_rd", 32'(bus.rf_rd), 32'(i));
        end
        idle_req();
        cyc();
        check_eq("burst_we_release", 32'(bus.rf_we), 32'd1);

        // LB rd=5 addr_lo=3, response after 4 cycles
        drive_req(5'd5, 32'd0, 1'b1, 3'b000, 2'd3);
        push_ev(K_WR, 5'd5, 32'hFFFF_FF80);
        cyc();
        idle_req();
        check_eq("lb_ex_ready_busy", 32'(bus.ex_ready), 32'd0);
        repeat (3) begin
            check_eq("lb_hz_pending", 32'(bus.hz_pending), 32'd1);
            check_eq("lb_hz_rd", 32'(bus.hz_rd), 32'd5);
            cyc();
        end
        pulse_rsp(32'h80FF_FF00);
        check_eq("lb_we", 32'(bus.rf_we), 32'd0);
        check_eq("lb_wd", bus.rf_wd, 32'hFFFF_FF80);
        check_eq("lb_hz_clear", 32'({bus.hz_pending, bus.hz_rd}), 32'd0);
        check_eq("lb_ex_ready_back", 32'(bus.ex_ready), 32'd1);

        // LHU addr_lo=2
        drive_req(5'd6, 32'd0, 1'b1, 3'b101, 2'd2);
        push_ev(K_WR, 5'd6, 32'h0000_BEEF);
        cyc();
        idle_req();
        pulse_rsp(32'hBEEF_1234);
        check_eq("lhu_wd", bus.rf_wd, 32'h0000_BEEF);

        // Misaligned LW and illegal funct3 are rejected without a write
        drive_req(5'd7, 32'd0, 1'b1, 3'b010, 2'd1);
        push_ev(K_MIS, 5'd0, 32'd0);
        cyc();
        idle_req();
        check_eq("lw_mis_pulse", 32'(bus.err_misalign), 32'd1);
        check_eq("lw_mis_idle", 32'(bus.ex_ready), 32'd1);
        check_eq("lw_mis_no_hz", 32'(bus.hz_pending), 32'd0);
        drive_req(5'd7, 32'd0, 1'b1, 3'b011, 2'd0);
        push_ev(K_MIS, 5'd0, 32'd0);
        cyc();
        idle_req();
        check_eq("f3_illegal_pulse", 32'(bus.err_misalign), 32'd1);
        cyc();
        check_eq("mis_pulse_single", 32'(bus.err_misalign), 32'd0);

        // No response: timeout after TIMEOUT waiting cycles
        drive_req(5'd9, 32'd0, 1'b1, 3'b010, 2'd0);
        push_ev(K_TMO, 5'd0, 32'd0);
        cyc();
        idle_req();
        for (int i = 1; i < int'(TIMEOUT); i++) begin
            check_eq("tmo_not_yet", 32'(bus.err_timeout), 32'd0);
            cyc();
        end
        check_eq("tmo_still_pending", 32'(bus.hz_pending), 32'd1);
        cyc();
        check_eq("tmo_pulse", 32'(bus.err_timeout), 32'd1);
        check_eq("tmo_hz_clear", 32'(bus.hz_pending), 32'd0);
        cyc();
        check_eq("tmo_pulse_single", 32'(bus.err_timeout), 32'd0);

        // Response on the final cycle wins over the timeout
        drive_req(5'd8, 32'd0, 1'b1, 3'b001, 2'd2);
        push_ev(K_WR, 5'd8, 32'hFFFF_8001);
        cyc();
        idle_req();
        repeat (int'(TIMEOUT) - 1) cyc();
        pulse_rsp(32'h8001_7FFF);
        check_eq("last_cycle_we", 32'(bus.rf_we), 32'd0);
        check_eq("last_cycle_no_tmo", 32'(bus.err_timeout), 32'd0);
        cyc();
        check_eq("last_cycle_no_tmo_late", 32'(bus.err_timeout), 32'd0);

        // rd=0 load and ALU: handshake completes, no write
        drive_req(5'd0, 32'd0, 1'b1, 3'b010, 2'd0);
        cyc();
        idle_req();
        check_eq("x0_hz_pending", 32'(bus.hz_pending), 32'd1);
        check_eq("x0_hz_rd", 32'(bus.hz_rd), 32'd0);
        pulse_rsp(32'hDEAD_BEEF);
        check_eq("x0_load_no_we", 32'(bus.rf_we), 32'd1);
        check_eq("x0_ex_ready", 32'(bus.ex_ready), 32'd1);
        drive_req(5'd0, 32'h1234_5678, 1'b0, 3'd0, 2'd0);
        cyc();
        idle_req();
        check_eq("x0_alu_no_we", 32'(bus.rf_we), 32'd1);

        // Response while idle is ignored
        pulse_rsp(32'hCAFE_F00D);
        check_eq("idle_rsp_no_we", 32'(bus.rf_we), 32'd1);

        // Reset during WAIT_RSP drops the load; a late response is ignored
        drive_req(5'd10, 32'd0, 1'b1, 3'b010, 2'd0);
        cyc();
        idle_req();
        cyc();
        rst_n = 1'b0;
        #1;
        check_eq("midrst_hz", 32'({bus.hz_pending, bus.hz_rd}), 32'd0);
        check_eq("midrst_ready", 32'(bus.ex_ready), 32'd1);
        check_eq("midrst_we", 32'(bus.rf_we), 32'd1);
        check_eq("midrst_rf_rd", 32'(bus.rf_rd), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        pulse_rsp(32'h0BAD_0BAD);
        check_eq("midrst_late_rsp", 32'(bus.rf_we), 32'd1);

        // Random mix of ALU writes and legal loads with short latencies
        for (int i = 0; i < 30; i++) begin
            rd = 5'($urandom_range(1, 31));
            if ($urandom_range(0, 1) == 0) begin
                wd = $urandom;
                drive_req(rd, wd, 1'b0, 3'd0, 2'd0);
                push_ev(K_WR, rd, wd);
                cyc();
                idle_req();
            end else begin
                f3   = f3_tab[$urandom_range(0, 4)];
                lo   = 2'($urandom_range(0, 3));
                if (f3 == 3'b010) lo = 2'd0;
                if (f3[0]) lo[0] = 1'b0;
                data = $urandom;
                lat  = int'($urandom_range(0, 5));
                drive_req(rd, 32'd0, 1'b1, f3, lo);
                push_ev(K_WR, rd, ref_fmt(f3, lo, data));
                cyc();
                idle_req();
                repeat (lat) cyc();
                pulse_rsp(data);
            end
        end
        repeat (3) cyc();

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
